// File: rtl/fetcher_icache.sv
// Instruction fetcher with a small fully-associative instruction buffer.
// Hits finish in one cycle; misses issue a valid/ready read and fill a round-robin entry.
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             hit
);

  localparam int PTR_BITS = (CACHE_LINES > 1) ? $clog2(CACHE_LINES) : 1;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } state_e;

  state_e                             state_q;
  logic                               mem_read_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q;
  logic                               hit_q;
  logic [CACHE_LINES-1:0]             valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   tag_q  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   data_q [CACHE_LINES];
  logic [PTR_BITS-1:0]                ptr_q;
  logic [PTR_BITS-1:0]                ptr_d;

  logic                               lookup_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   lookup_data;

  // Tags are unique, so at most one entry can match.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < CACHE_LINES; i++) begin
      if (valid_q[PTR_BITS'(i)] && (tag_q[PTR_BITS'(i)] == current_pc)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[PTR_BITS'(i)];
      end
    end
  end

  assign ptr_d = ptr_q + PTR_BITS'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      instruction_q      <= '0;
      hit_q              <= 1'b0;
      valid_q            <= '0;
      ptr_q              <= '0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lookup_hit && !flush) begin
              instruction_q <= lookup_data;
              hit_q         <= 1'b1;
              state_q       <= ST_FETCHED;
            end else begin
              mem_read_valid_q   <= 1'b1;
              mem_read_address_q <= current_pc;
              state_q            <= ST_FETCHING;
            end
          end
        end
        ST_FETCHING: begin
          if (mem_read_ready) begin
            instruction_q    <= mem_read_data;
            mem_read_valid_q <= 1'b0;
            state_q          <= ST_FETCHED;
            if (!flush) begin
              valid_q[ptr_q] <= 1'b1;
              tag_q[ptr_q]   <= mem_read_address_q;
              data_q[ptr_q]  <= mem_read_data;
              ptr_q          <= ptr_d;
            end
          end
        end
        ST_FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Flush wins over any fill on the same edge; an in-flight request continues.
      if (flush) begin
        valid_q <= '0;
        ptr_q   <= '0;
      end
    end
  end

  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = mem_read_address_q;
  assign fetcher_state    = state_q;
  assign instruction      = instruction_q;
  assign hit              = hit_q;

endmodule
